// File: rtl/core_weight_loader_if.sv
// Weight-beat stream bundle: valid/ready handshake plus payload.
// Ports: in_valid (src->dst), in_data (src->dst), in_ready (dst->src).
interface core_weight_loader_if #(
  parameter int BUS_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [BUS_W-1:0] in_data;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/core_weight_loader.sv
// Assembles BUS_W-bit stream beats into ROW_W-bit weight rows and writes
// each row into the Core macro with a one-cycle STDW pulse at STD_A.
// Ports: clk, rst_n (async low); start/start_row/num_rows load request;
// s (stream slave); STDW/STD_A/weight_in to Core; busy, done status.
module core_weight_loader #(
  parameter  int BUS_W = 32,
  parameter  int ROW_W = 288,
  parameter  int ROWS  = 64,
  localparam int BEATS = ROW_W / BUS_W,
  localparam int AW    = $clog2(ROWS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [AW-1:0]      start_row,
  input  logic [AW:0]        num_rows,
  core_weight_loader_if.slave s,
  output logic               STDW,
  output logic [AW-1:0]      STD_A,
  output logic [ROW_W-1:0]   weight_in,
  output logic               busy,
  output logic               done
);

  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [AW:0]      left_q, left_d;
  logic             stdw_q, stdw_d;
  logic [AW-1:0]    stda_q, stda_d;
  logic [ROW_W-1:0] wout_q, wout_d;

  logic             xfer;
  logic             last_beat;
  logic [AW:0]      eff_rows;
  logic [ROW_W-1:0] row_ins;

  assign s.in_ready = (state_q == S_FILL);
  assign xfer       = s.in_valid && s.in_ready;
  assign last_beat  = (beat_q == BW'(BEATS - 1));

  assign eff_rows = (num_rows > (AW+1)'(ROWS))
                  ? (AW+1)'(ROWS) : num_rows;

  // Current row with the incoming beat dropped into its slot,
  // so the last beat lands straight in the output register.
  always_comb begin
    row_ins = row_q;
    for (int k = 0; k < BEATS; k++) begin
      if (beat_q == BW'(k)) begin
        row_ins[k*BUS_W +: BUS_W] = s.in_data;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    row_d   = row_q;
    addr_d  = addr_q;
    left_d  = left_q;
    stdw_d  = 1'b0;
    stda_d  = stda_q;
    wout_d  = wout_q;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (start) begin
          addr_d  = start_row;
          left_d  = eff_rows;
          beat_d  = '0;
          state_d = (eff_rows == '0) ? S_DONE : S_FILL;
        end
      end
      (state_q == S_FILL): begin
        if (xfer) begin
          row_d = row_ins;
          if (last_beat) begin
            beat_d  = '0;
            stdw_d  = 1'b1;
            stda_d  = addr_q;
            wout_d  = row_ins;
            state_d = S_WRITE;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      (state_q == S_WRITE): begin
        addr_d  = addr_q + AW'(1);
        left_d  = left_q - (AW+1)'(1);
        state_d = (left_q == (AW+1)'(1))
                ? S_DONE : S_FILL;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      row_q   <= '0;
      addr_q  <= '0;
      left_q  <= '0;
      stdw_q  <= 1'b0;
      stda_q  <= '0;
      wout_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      left_q  <= left_d;
      stdw_q  <= stdw_d;
      stda_q  <= stda_d;
      wout_q  <= wout_d;
    end
  end

  assign STDW      = stdw_q;
  assign STD_A     = stda_q;
  assign weight_in = wout_q;
  assign busy      = (state_q == S_FILL) ||
                     (state_q == S_WRITE);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_core_weight_loader.sv
// Bench for core_weight_loader: queue model of expected Core writes
// plus directed loads with hand-computed timing and contents.
module tb_core_weight_loader;

  localparam int BUS_W = 32;
  localparam int ROW_W = 288;
  localparam int NB    = ROW_W / BUS_W;

  typedef struct {
    logic [5:0]       a;
    logic [ROW_W-1:0] d;
  } wr_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [5:0]       start_row = '0;
  logic [6:0]       num_rows = '0;
  logic             STDW;
  logic [5:0]       STD_A;
  logic [ROW_W-1:0] weight_in;
  logic             busy;
  logic             done;

  core_weight_loader_if #(.BUS_W(BUS_W)) s_if ();

  core_weight_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .start_row (start_row),
    .num_rows  (num_rows),
    .s         (s_if),
    .STDW      (STDW),
    .STD_A     (STD_A),
    .weight_in (weight_in),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nwr = 0;
  logic             prev_stdw = 1'b0;
  logic [5:0]       last_a = '0;
  logic [ROW_W-1:0] last_d = '0;
  logic [31:0]      beats[$];
  wr_t              expq[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [ROW_W-1:0] act,
                     logic [ROW_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Per-cycle compare against the expected write queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stdw = 1'b0;
    end else begin
      chk("ready_vs_busy", s_if.in_ready, busy && !STDW);
      if (STDW) begin
        nwr++;
        last_a = STD_A;
        last_d = weight_in;
        chk("stdw_not_back_to_back", prev_stdw, 1'b0);
        if (expq.size() == 0) begin
          chk("unexpected_stdw", 1'b1, 1'b0);
        end else begin
          wr_t e;
          e = expq.pop_front();
          chk("std_a", STD_A, e.a);
          chk("weight_in", weight_in, e.d);
        end
      end
      prev_stdw = STDW;
    end
  end

  task automatic fill_beats(int n, int mode, int seed);
    beats.delete();
    for (int i = 0; i < n; i++) begin
      if (mode == 0) beats.push_back(32'h1111_1111);
      else if (mode == 1) beats.push_back(32'(i));
      else beats.push_back(32'(i) * 32'h9E37_79B1 + 32'(seed));
    end
  endtask

  function automatic int eff_of(int n);
    return (n > 64) ? 64 : n;
  endfunction

  task automatic push_expected(int sr, int n);
    for (int i = 0; i < eff_of(n); i++) begin
      wr_t e;
      e.a = 6'((sr + i) % 64);
      e.d = '0;
      for (int k = 0; k < NB; k++) begin
        e.d[k*BUS_W +: BUS_W] = beats[i*NB + k];
      end
      expq.push_back(e);
    end
  endtask

  task automatic stream(int nb, bit stall, output int xf);
    int i;
    int guard;
    bit x;
    i = 0;
    guard = 0;
    xf = 0;
    while (i < nb && guard < 4000) begin
      s_if.in_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      s_if.in_data  = s_if.in_valid ? beats[i] : 32'hDEAD_BEEF;
      @(negedge clk);
      x = s_if.in_valid && s_if.in_ready;
      @(posedge clk);
      #1;
      guard++;
      if (x) begin
        i++;
        xf++;
      end
    end
    s_if.in_valid = 1'b0;
    if (i < nb) chk("stream_timeout", 32'(i), 32'(nb));
  endtask

  // Called just after a posedge with the DUT idle.
  task automatic run_load(int sr, int n, bit stall, bit poke,
                          output int dcyc, output int xf);
    int c0;
    push_expected(sr, n);
    start     = 1'b1;
    start_row = 6'(sr);
    num_rows  = 7'(n);
    c0 = cyc;
    dcyc = -1;
    @(posedge clk);
    #1;
    start = 1'b0;
    fork
      stream(eff_of(n) * NB, stall, xf);
      begin : waiter
        for (int k = 0; k < 3000; k++) begin
          @(negedge clk);
          if (done) begin
            dcyc = cyc - c0;
            break;
          end
        end
        if (dcyc < 0) chk("done_timeout", 1'b0, 1'b1);
      end
      if (poke) begin
        repeat (5) @(posedge clk);
        #1;
        start     = 1'b1;
        start_row = 6'd33;
        num_rows  = 7'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
    join
    @(posedge clk);
    #1;
    chk("queue_drained", 32'(expq.size()), 32'd0);
  endtask

  task automatic chk_outputs_zero(string tag);
    chk({tag, "_stdw"},  STDW, 1'b0);
    chk({tag, "_std_a"}, STD_A, 6'd0);
    chk({tag, "_wdata"}, weight_in, '0);
    chk({tag, "_ready"}, s_if.in_ready, 1'b0);
    chk({tag, "_busy"},  busy, 1'b0);
    chk({tag, "_done"},  done, 1'b0);
  endtask

  initial begin
    int dc;
    int xf;
    int w0;
    s_if.in_valid = 1'b0;
    s_if.in_data  = '0;
    #2;
    chk_outputs_zero("reset");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Full 64-row load from row 0, no stalls.
    fill_beats(64 * NB, 0, 0);
    w0 = nwr;
    run_load(0, 64, 1'b0, 1'b0, dc, xf);
    chk("basic_done_cyc", 32'(dc), 32'd641);
    chk("basic_writes", 32'(nwr - w0), 32'd64);
    chk("basic_last_a", last_a, 6'd63);
    chk("basic_row", last_d, {9{32'h1111_1111}});

    // Address wrap, with a start poked mid-load.
    fill_beats(4 * NB, 2, 7);
    w0 = nwr;
    run_load(62, 4, 1'b0, 1'b1, dc, xf);
    chk("wrap_done_cyc", 32'(dc), 32'd41);
    chk("wrap_writes", 32'(nwr - w0), 32'd4);
    chk("wrap_last_a", last_a, 6'd1);

    // Beat ordering.
    fill_beats(NB, 1, 0);
    run_load(5, 1, 1'b0, 1'b0, dc, xf);
    chk("order_done_cyc", 32'(dc), 32'd11);
    chk("order_lo", last_d[31:0], 32'd0);
    chk("order_hi", last_d[287:256], 32'd8);
    chk("order_a", last_a, 6'd5);

    // Backpressure: same rows, stalled vs not.
    fill_beats(3 * NB, 2, 99);
    run_load(20, 3, 1'b0, 1'b0, dc, xf);
    chk("nostall_done_cyc", 32'(dc), 32'd31);
    w0 = nwr;
    run_load(20, 3, 1'b1, 1'b0, dc, xf);
    chk("stall_xfers", 32'(xf), 32'd27);
    chk("stall_writes", 32'(nwr - w0), 32'd3);
    chk("stall_last_a", last_a, 6'd22);

    // Zero rows, then a start in the DONE cycle.
    w0 = nwr;
    start     = 1'b1;
    start_row = 6'd7;
    num_rows  = 7'd0;
    dc = cyc;
    @(posedge clk);
    #1;
    start    = 1'b0;
    num_rows = 7'd5;
    @(negedge clk);
    chk("zero_done", done, 1'b1);
    chk("zero_done_cyc", 32'(cyc - dc), 32'd1);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("start_in_done_busy", busy, 1'b0);
    chk("zero_writes", 32'(nwr - w0), 32'd0);
    @(posedge clk);
    #1;

    // Count above 64 clamps.
    fill_beats(64 * NB, 2, 3);
    w0 = nwr;
    run_load(3, 100, 1'b0, 1'b0, dc, xf);
    chk("clamp_writes", 32'(nwr - w0), 32'd64);
    chk("clamp_done_cyc", 32'(dc), 32'd641);
    chk("clamp_last_a", last_a, 6'd2);

    // Reset after the 4th beat of row 2.
    fill_beats(4 * NB, 2, 55);
    push_expected(10, 4);
    w0 = nwr;
    start     = 1'b1;
    start_row = 6'd10;
    num_rows  = 7'd4;
    @(posedge clk);
    #1;
    start = 1'b0;
    stream(2 * NB + 4, 1'b0, xf);
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("midrst");
    chk("midrst_pending", 32'(expq.size()), 32'd2);
    chk("midrst_writes", 32'(nwr - w0), 32'd2);
    expq.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    fill_beats(2 * NB, 2, 1234);
    w0 = nwr;
    run_load(40, 2, 1'b0, 1'b0, dc, xf);
    chk("fresh_done_cyc", 32'(dc), 32'd21);
    chk("fresh_writes", 32'(nwr - w0), 32'd2);
    chk("fresh_last_a", last_a, 6'd41);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/core_weight_loader.md
# core_weight_loader

Upstream feeder for the `Core` CIM macro's weight-update port. It accepts weight data from a narrow valid/ready stream and assembles each full 288-bit weight row (72 × 4b) from consecutive beats. It then writes each row into `Core` with a one-cycle `STDW` pulse at a sequentially incrementing `STD_A`, covering a programmable range of the 64 rows. It drives `Core`'s `STDW`, `STD_A` and `weight_in` directly and signals completion to the controller.

## Interface
- `BUS_W`, 32: stream beat width in bits.
- `ROW_W`, 288: weight row width (72 × 4b); `ROW_W % BUS_W == 0` is required.
- `ROWS`, 64: number of rows in `Core`; address width is log2(`ROWS`) = 6.
- `BEATS`, derived `ROW_W/BUS_W` = 9: beats per row; not overridable.

- `clk`  in  1  single clock; all logic is posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a load; sampled only in IDLE.
- `start_row`  in  6  first `Core` row address; sampled with `start`.
- `num_rows`  in  7  rows to load; sampled with `start`.
- `in_valid`  in  1  stream beat valid.
- `in_ready`  out  1  stream beat ready.
- `in_data`  in  `BUS_W`  stream beat payload.
- `STDW`  out  1  `Core` weight-write strobe.
- `STD_A`  out  6  `Core` row address.
- `weight_in`  out  `ROW_W`  `Core` weight row.
- `busy`  out  1  a load is in progress.
- `done`  out  1  one-cycle completion pulse.

## Operation
- **States.**
  - IDLE: `start` moves the block to FILL, or to DONE if the effective row count is 0.
  - FILL: accept beats. When the `BEATS`-th beat is accepted, go to WRITE.
  - WRITE: one cycle. Go to FILL if rows remain, else to DONE.
  - DONE: one cycle, then IDLE.
- **Row count.** The effective count is `num_rows` clamped to 64. A value of 0 produces a `done` pulse with no writes.
- **Beat packing.** Beats are packed little-endian: beat k fills `row[k*BUS_W +: BUS_W]`, for k = 0..8.
  - The beat counter resets to 0 when entering FILL from IDLE and after every WRITE.
- **Handshake.** A transfer occurs when `in_valid && in_ready`.
  - `in_ready` = 1 only in FILL.
  - `in_valid` may stall indefinitely. The block has no timeout.
  - `in_data` is ignored when no transfer occurs.
- **Write cycle.**
  - In WRITE: `STDW` = 1, `STD_A` = current address, `weight_in` = the assembled row. All three are registered outputs.
  - On leaving WRITE: address = address + 1, modulo 64 (63 wraps to 0), and rows remaining decrements.
  - Outside WRITE: `STDW` = 0. `STD_A` and `weight_in` hold their last driven values.
- **Status outputs.**
  - `busy` = 1 in FILL and WRITE, and 0 in IDLE and DONE.
  - `done` = 1 only in DONE.
- **`start` handling.** `start` is ignored outside IDLE. A `start` asserted in the DONE cycle is also ignored.
- **Reset.** Asserting `rst_n` low at any time forces IDLE and discards any partial row.
  - All outputs go to 0: `STDW`, `STD_A`, `weight_in`, `in_ready`, `busy`, `done`.
  - Rows already written to `Core` are not rolled back.
- **Excluded features.** The block has no readback (`STDR`) and no activation handling. Those belong to other stages.

## Timing
- **Cycle sequence.**
  - Cycle t: IDLE with `start` = 1.
  - Cycle t+1: FILL, `busy` = 1, `in_ready` = 1.
  - With `in_valid` held at 1, beats are accepted on cycles t+1 through t+9.
  - Cycle t+10: WRITE with `STDW` = 1.
  - Cycle t+11: FILL for the next row, or DONE with `done` = 1.
- **Throughput.** Best case is 10 cycles per row. A load of N rows with no stalls has `done` at cycle t + 10N + 1.
- **Write shape.** `STDW` is never high for two consecutive cycles.
- **Output stability.** `STD_A` and `weight_in` are stable for the entire cycle in which `STDW` is high. `Core` samples them at the following posedge.
- **Reset.** Reset is asynchronous: outputs clear without waiting for a clock edge. The first `start` is accepted on the first posedge after `rst_n` rises.

## Test plan
- **Basic load with wrap.**
  - Stimulus: reset, then `start`, `start_row`=0, `num_rows`=64. Stream every beat as 0x11111111, with `in_valid` held at 1.
  - Required: 64 `STDW` pulses at `STD_A` 0..63, each with `weight_in` = 288'h1111…1. `done` at cycle t+641.
  - Follow-on: `start_row`=62, `num_rows`=4 writes `STD_A` 62, 63, 0, 1.
- **Beat ordering.**
  - Stimulus: `num_rows`=1, beats 0x00000000 through 0x00000008.
  - Required: `weight_in[31:0]`=0 and `weight_in[287:256]`=8 in the WRITE cycle.
- **Backpressure.**
  - Stimulus: `in_valid` toggles randomly at 50%, `num_rows`=3.
  - Required: row contents and addresses match the no-stall run, and exactly 27 transfers occur.
- **Boundary counts.**
  - Stimulus: `num_rows`=0, then `num_rows`=100.
  - Required: `num_rows`=0 gives `done` at t+1 with no `STDW`. `num_rows`=100 gives exactly 64 writes.
- **Mid-load reset and ignored start.**
  - Stimulus: assert `rst_n` low after the 4th beat of row 2.
  - Required: all outputs are 0 immediately. No further `STDW` occurs, and a new load afterwards writes fresh rows correctly.
  - Additional check: `start` pulsed while `busy` has no effect.
